// File: rtl/aaf_frame_ctrl.sv
// aaf_frame_ctrl: frame sequencer gating one H*V pixel frame at a time into the AAF core,
// holding the filter enable through drain and reporting irqs and drain timeouts.
module aaf_frame_ctrl #(
  parameter int DW    = 16,
  parameter int H     = 1280,
  parameter int V     = 720,
  parameter int HW    = 11,
  parameter int VW    = 10,
  parameter int TMO_W = 16,
  parameter int FW    = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cfg_start,
  input  logic             cfg_abort,
  input  logic [FW-1:0]    cfg_frame_num,
  input  logic [TMO_W-1:0] cfg_drain_tmo,
  input  logic [DW-1:0]    s_data,
  input  logic             s_vld,
  output logic             s_rdy,
  output logic             f_en,
  output logic [DW-1:0]    f_data,
  output logic             f_vld,
  input  logic             f_done,
  output logic             busy,
  output logic [FW-1:0]    frame_cnt,
  output logic             irq_frame,
  output logic             irq_run,
  output logic             err_tmo
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ARM   = 3'd1;
  localparam logic [2:0] FEED  = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] NEXT  = 3'd4;
  localparam logic [2:0] ERR   = 3'd5;
  logic [2:0] state, nxt;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [FW-1:0] fc_inc;
  logic abort, acc, h_last, last, run_end;
  assign busy = state != IDLE;
  assign abort = cfg_abort & busy;
  assign s_rdy = state == FEED;
  assign f_en = (state == ARM) || (state == FEED) || (state == DRAIN);
  assign acc = s_vld & s_rdy;
  assign h_last = h_cnt == HW'(H - 1);
  assign last = acc & h_last & (v_cnt == VW'(V - 1));
  assign fc_inc = frame_cnt + 1'b1;
  assign run_end = (cfg_frame_num != '0) && (fc_inc == cfg_frame_num);
  // an abort landing on NEXT suppresses the frame's irqs
  assign irq_frame = (state == NEXT) && !abort;
  assign irq_run = irq_frame && run_end;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = (cfg_start && !cfg_abort) ? ARM : IDLE;
      ARM:     nxt = FEED;
      FEED:    nxt = last ? DRAIN : FEED;
      DRAIN:   nxt = f_done ? NEXT : (tmo_cnt == cfg_drain_tmo) ? ERR : DRAIN;
      NEXT:    nxt = run_end ? IDLE : ARM;
      ERR:     nxt = ERR;
      default: nxt = IDLE;
    endcase
    if (abort) nxt = IDLE;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      h_cnt     <= '0;
      v_cnt     <= '0;
      tmo_cnt   <= '0;
      frame_cnt <= '0;
      f_data    <= '0;
      f_vld     <= 1'b0;
      err_tmo   <= 1'b0;
    end else begin
      state   <= nxt;
      f_vld   <= acc & ~abort;
      if (acc) f_data <= s_data;
      tmo_cnt <= (state == DRAIN && !abort) ? tmo_cnt + 1'b1 : '0;
      if (abort || state == ARM) begin
        h_cnt <= '0;
        v_cnt <= '0;
      end else if (acc) begin
        h_cnt <= h_last ? '0 : h_cnt + 1'b1;
        if (h_last) v_cnt <= v_cnt + 1'b1;
      end
      if (abort || (state == IDLE && nxt == ARM)) frame_cnt <= '0;
      else if (state == NEXT) frame_cnt <= fc_inc;
      if (abort) err_tmo <= 1'b0;
      else if (nxt == ERR) err_tmo <= 1'b1;
    end
  end
endmodule

// File: tb/tb_aaf_frame_ctrl.sv
// tb_aaf_frame_ctrl: directed scenario bench for aaf_frame_ctrl with an 8x4 frame.
module tb_aaf_frame_ctrl;
  logic clk, rstn, cfg_start, cfg_abort, s_vld, s_rdy, f_en, f_vld, f_done;
  logic busy, irq_frame, irq_run, err_tmo;
  logic [7:0] cfg_frame_num, frame_cnt;
  logic [15:0] cfg_drain_tmo, s_data, f_data, dnext;
  int pass_cnt = 0, total_cnt = 0;

  aaf_frame_ctrl #(.DW(16), .H(8), .V(4), .HW(11), .VW(10), .TMO_W(16), .FW(8)) dut (
    .clk(clk), .rstn(rstn), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_frame_num(cfg_frame_num), .cfg_drain_tmo(cfg_drain_tmo),
    .s_data(s_data), .s_vld(s_vld), .s_rdy(s_rdy), .f_en(f_en), .f_data(f_data),
    .f_vld(f_vld), .f_done(f_done), .busy(busy), .frame_cnt(frame_cnt),
    .irq_frame(irq_frame), .irq_run(irq_run), .err_tmo(err_tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic start_run(input logic [7:0] n);
    cfg_frame_num = n;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  // Drives one frame from ARM; returns on the 2nd DRAIN cycle (tmo_cnt==1).
  task automatic feed(input bit gaps, output int beats, output int bad, output int accepts);
    logic pend = 1'b0;
    logic [15:0] pd = '0;
    beats = 0; bad = 0; accepts = 0;
    for (int i = 0; i < 400 && !(accepts >= 32 && !pend); i++) begin
      if (f_vld) begin
        beats++;
        if (!pend || f_data !== pd) bad++;
      end else if (pend) bad++;
      pend = 1'b0;
      s_vld = (accepts >= 32) ? 1'b1 : (gaps ? 1'($urandom_range(0, 1)) : 1'b1);
      s_data = dnext;
      if (s_vld && s_rdy) begin
        accepts++;
        pend = 1'b1;
        pd = s_data;
        dnext++;
      end
      @(negedge clk);
    end
    s_vld = 1'b0;
  endtask

  // Raises f_done for one cycle in the DRAIN cycle where tmo_cnt==d (d>=1).
  task automatic drain(input int d);
    repeat (d - 1) @(negedge clk);
    f_done = 1'b1;
    @(negedge clk);
    f_done = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    total_cnt++; if ({s_rdy, f_en, f_vld, busy, irq_frame, irq_run, err_tmo, f_data, frame_cnt} !== '0) $display("FAIL reset_outputs got=%h exp=0", {s_rdy, f_en, f_vld, busy, irq_frame, irq_run, err_tmo, f_data, frame_cnt}); else pass_cnt++;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_idle busy got=%b exp=0", busy); else pass_cnt++;
  endtask

  task automatic test_two_frames;
    int b, bad, a;
    start_run(8'd2);
    total_cnt++; if (f_en !== 1'b1 || s_rdy !== 1'b0) $display("FAIL t1_arm f_en/s_rdy got=%b%b exp=10", f_en, s_rdy); else pass_cnt++;
    feed(1'b0, b, bad, a);
    total_cnt++; if (b !== 32) $display("FAIL t1_f1_beats got=%0d exp=32", b); else pass_cnt++;
    total_cnt++; if (bad !== 0 || a !== 32) $display("FAIL t1_f1_data bad=%0d accepts=%0d exp 0/32", bad, a); else pass_cnt++;
    drain(5);
    total_cnt++; if ({irq_frame, irq_run, f_en} !== 3'b100) $display("FAIL t1_next1 irq_frame/irq_run/f_en got=%b exp=100", {irq_frame, irq_run, f_en}); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if ({f_en, irq_frame} !== 2'b10 || frame_cnt !== 8'd1) $display("FAIL t1_rearm f_en/irq=%b frame_cnt=%0d exp 10/1", {f_en, irq_frame}, frame_cnt); else pass_cnt++;
    feed(1'b0, b, bad, a);
    total_cnt++; if (b !== 32 || bad !== 0 || a !== 32) $display("FAIL t1_f2 beats=%0d bad=%0d accepts=%0d exp 32/0/32", b, bad, a); else pass_cnt++;
    drain(5);
    total_cnt++; if ({irq_frame, irq_run, f_en} !== 3'b110) $display("FAIL t1_next2 irq_frame/irq_run/f_en got=%b exp=110", {irq_frame, irq_run, f_en}); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if ({busy, f_en, irq_run} !== 3'b000 || frame_cnt !== 8'd2) $display("FAIL t1_end busy/f_en/irq_run=%b frame_cnt=%0d exp 000/2", {busy, f_en, irq_run}, frame_cnt); else pass_cnt++;
  endtask

  task automatic test_gaps;
    int b, bad, a;
    start_run(8'd1);
    feed(1'b1, b, bad, a);
    total_cnt++; if (b !== 32 || bad !== 0) $display("FAIL t2_beats beats=%0d bad=%0d exp 32/0", b, bad); else pass_cnt++;
    total_cnt++; if (a !== 32 || s_rdy !== 1'b0) $display("FAIL t2_hold accepts=%0d s_rdy=%b exp 32/0", a, s_rdy); else pass_cnt++;
    drain(3);
    total_cnt++; if (irq_run !== 1'b1) $display("FAIL t2_irq_run got=%b exp=1", irq_run); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (busy !== 1'b0 || frame_cnt !== 8'd1) $display("FAIL t2_end busy=%b frame_cnt=%0d exp 0/1", busy, frame_cnt); else pass_cnt++;
  endtask

  task automatic test_timeout;
    int b, bad, a, n;
    start_run(8'd1);
    feed(1'b0, b, bad, a);
    n = 0;
    for (int i = 0; i < 50 && f_en; i++) begin
      @(negedge clk);
      n++;
    end
    total_cnt++; if (n !== 20) $display("FAIL t3_tmo_cycles got=%0d exp=20", n); else pass_cnt++;
    total_cnt++; if ({err_tmo, busy, f_en, s_rdy, irq_frame} !== 5'b11000) $display("FAIL t3_err err/busy/f_en/s_rdy/irq got=%b exp=11000", {err_tmo, busy, f_en, s_rdy, irq_frame}); else pass_cnt++;
    start_run(8'd1);
    @(negedge clk);
    total_cnt++; if ({err_tmo, busy, f_en} !== 3'b110) $display("FAIL t3_start_ignored err/busy/f_en got=%b exp=110", {err_tmo, busy, f_en}); else pass_cnt++;
    cfg_abort = 1'b1;
    @(negedge clk);
    cfg_abort = 1'b0;
    total_cnt++; if ({err_tmo, busy} !== 2'b00) $display("FAIL t3_abort err/busy got=%b exp=00", {err_tmo, busy}); else pass_cnt++;
  endtask

  task automatic test_done_at_tmo;
    int b, bad, a;
    start_run(8'd1);
    feed(1'b0, b, bad, a);
    drain(20);
    total_cnt++; if ({irq_frame, err_tmo, f_en} !== 3'b100) $display("FAIL t4_next irq/err/f_en got=%b exp=100", {irq_frame, err_tmo, f_en}); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if ({busy, err_tmo} !== 2'b00) $display("FAIL t4_end busy/err got=%b exp=00", {busy, err_tmo}); else pass_cnt++;
  endtask

  task automatic test_abort;
    int b, bad, a;
    start_run(8'd1);
    s_vld = 1'b1;
    s_data = dnext;
    repeat (14) begin
      @(negedge clk);
      dnext++;
      s_data = dnext;
    end
    cfg_abort = 1'b1;
    @(negedge clk);
    cfg_abort = 1'b0;
    s_vld = 1'b0;
    total_cnt++; if ({s_rdy, f_en, busy, f_vld, irq_frame, irq_run} !== 6'b0) $display("FAIL t5_abort s_rdy/f_en/busy/f_vld/irqs got=%b exp=000000", {s_rdy, f_en, busy, f_vld, irq_frame, irq_run}); else pass_cnt++;
    start_run(8'd1);
    feed(1'b0, b, bad, a);
    total_cnt++; if (b !== 32 || bad !== 0 || a !== 32) $display("FAIL t5_clean beats=%0d bad=%0d accepts=%0d exp 32/0/32", b, bad, a); else pass_cnt++;
    drain(5);
    total_cnt++; if (irq_run !== 1'b1) $display("FAIL t5_irq_run got=%b exp=1", irq_run); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (frame_cnt !== 8'd1) $display("FAIL t5_frame_cnt got=%0d exp=1", frame_cnt); else pass_cnt++;
  endtask

  task automatic test_continuous_reset;
    int b, bad, a, runs;
    runs = 0;
    start_run(8'd0);
    for (int f = 0; f < 3; f++) begin
      feed(1'b0, b, bad, a);
      drain(2);
      if (irq_run) runs++;
      @(negedge clk);
    end
    total_cnt++; if (runs !== 0) $display("FAIL t6_irq_run got=%0d exp=0", runs); else pass_cnt++;
    total_cnt++; if (frame_cnt !== 8'd3 || f_en !== 1'b1) $display("FAIL t6_cont frame_cnt=%0d f_en=%b exp 3/1", frame_cnt, f_en); else pass_cnt++;
    s_vld = 1'b1;
    repeat (10) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    total_cnt++; if ({s_rdy, f_en, f_vld, busy, irq_frame, irq_run, err_tmo, f_data, frame_cnt} !== '0) $display("FAIL t6_async_reset got=%h exp=0", {s_rdy, f_en, f_vld, busy, irq_frame, irq_run, err_tmo, f_data, frame_cnt}); else pass_cnt++;
    @(negedge clk);
    s_vld = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
    total_cnt++; if ({busy, s_rdy, f_en} !== 3'b000) $display("FAIL t6_idle busy/s_rdy/f_en got=%b exp=000", {busy, s_rdy, f_en}); else pass_cnt++;
  endtask

  initial begin
    rstn = 1'b0; cfg_start = 1'b0; cfg_abort = 1'b0; cfg_frame_num = '0;
    cfg_drain_tmo = 16'd20; s_data = '0; s_vld = 1'b0; f_done = 1'b0; dnext = 16'h0100;
    test_reset;
    test_two_frames;
    test_gaps;
    test_timeout;
    test_done_at_tmo;
    test_abort;
    test_continuous_reset;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
